// File: rtl/tx_link_ctrl.sv
// ============================================================================
// tx_link_ctrl -- JESD204B transmit link-layer controller
//
// Sits directly upstream of the ILA generator. It keeps the local frame/LMFC
// position and watches the receiver's SYNC~ to sequence the lane through
// CGS (K28.5) -> ILA -> user DATA. It issues the ILA start pulse, records the
// frame phase at which SYNC~ was released, and classifies SYNC~ low periods
// seen after link-up as either error reports (short) or resync requests (long).
//
// Optional build feature: define TX_LMFC_SYSREF_EN to add an i_sysref input
// whose rising edge realigns the LMFC counters to zero.
//
// Ports:
//   clk                      in   1  character clock
//   rst_n                    in   1  asynchronous, active-low reset
//   i_link_en                in   1  link enable; low forces DISABLED
//   i_sync_n                 in   1  SYNC~ (already synchronised), active low
//   i_F                      in   8  octets per frame, encoded F-1
//   i_K                      in   5  frames per multiframe, encoded K-1
//   i_seq_end                in   1  ILA generator end pulse
//   i_sysref                 in   1  SYSREF (only with TX_LMFC_SYSREF_EN)
//   o_seq_start              out  1  one-cycle ILA start pulse
//   o_no_frame_de_assertion  out  5  frame position captured when SYNC~ rose
//   o_sel                    out  2  lane source: 0 K28.5, 1 ILA, 2 data
//   o_octet_pos              out  8  octet position in frame
//   o_frame_pos              out  5  frame position in multiframe
//   o_lmfc_edge              out  1  high on octet 0 of frame 0
//   o_sync_err               out  1  one-cycle pulse: short SYNC~ low
//   o_resync                 out  1  one-cycle pulse: resync accepted
//   o_ila_abort              out  1  one-cycle pulse: ILA abandoned by resync
// ============================================================================
module tx_link_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_link_en,
    input  logic       i_sync_n,
    input  logic [7:0] i_F,
    input  logic [4:0] i_K,
    input  logic       i_seq_end,
`ifdef TX_LMFC_SYSREF_EN
    input  logic       i_sysref,
`endif
    output logic       o_seq_start,
    output logic [4:0] o_no_frame_de_assertion,
    output logic [1:0] o_sel,
    output logic [7:0] o_octet_pos,
    output logic [4:0] o_frame_pos,
    output logic       o_lmfc_edge,
    output logic       o_sync_err,
    output logic       o_resync,
    output logic       o_ila_abort
);

    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_CGS       = 3'd1,
        ST_WAIT_LMFC = 3'd2,
        ST_ILA       = 3'd3,
        ST_DATA      = 3'd4
    } state_t;

    localparam logic [1:0] SEL_K28 = 2'd0;
    localparam logic [1:0] SEL_ILA = 2'd1;
    localparam logic [1:0] SEL_DAT = 2'd2;

    localparam logic [10:0] LOWCNT_MAX = 11'h7FF;

    state_t      state_q, state_d;

    logic [7:0]  octet_q, octet_d;
    logic [4:0]  frame_q, frame_d;
    logic [10:0] lowcnt_q, lowcnt_d;
    logic [4:0]  nfda_q, nfda_d;
    logic        seq_start_q, seq_start_d;
    logic        sync_err_q, sync_err_d;
    logic        resync_q, resync_d;
    logic        ila_abort_q, ila_abort_d;
    logic [1:0]  sel_c;

    logic        octet_wrap;
    logic        frame_wrap;
    logic        lmfc_wrap;
    logic        boundary;
    logic [10:0] f_plus1;
    logic [10:0] th;
    logic        low_hit;
    logic        short_low_end;
    logic        sysref_rise;
    logic        realign;

    // ------------------------------------------------------------------
    // LMFC position. Wrap uses >= so that shrinking i_F / i_K while
    // running wraps on the next increment instead of counting through
    // the whole 8/5-bit range.
    // ------------------------------------------------------------------
    assign octet_wrap = (octet_q >= i_F);
    assign frame_wrap = (frame_q >= i_K);
    assign lmfc_wrap  = octet_wrap && frame_wrap;

    // Last octet of the last frame: the next cycle is the LMFC edge.
    assign boundary   = (octet_q == i_F) && (frame_q == i_K);

`ifdef TX_LMFC_SYSREF_EN
    logic sysref_q, sysref_d;

    assign sysref_d    = i_sysref;
    assign sysref_rise = i_sysref && !sysref_q;
    // A SYSREF edge landing exactly where the counters would wrap anyway
    // leaves the phase untouched, so it must not disturb the link.
    assign realign     = sysref_rise && !lmfc_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sysref_q <= 1'b0;
        end else begin
            sysref_q <= sysref_d;
        end
    end
`else
    assign sysref_rise = 1'b0;
    assign realign     = 1'b0;
`endif

    always_comb begin
        octet_d = octet_q + 8'd1;
        frame_d = frame_q;
        if (octet_wrap) begin
            octet_d = '0;
            frame_d = frame_wrap ? 5'd0 : (frame_q + 5'd1);
        end
        if (sysref_rise) begin
            octet_d = '0;
            frame_d = '0;
        end
    end

    assign o_lmfc_edge = (octet_q == 8'd0) && (frame_q == 5'd0);

    // ------------------------------------------------------------------
    // SYNC~ low-time measurement.
    // th = 5*F + 9 with F = i_F+1; at most 5*256+9 = 1289, so 11 bits hold
    // both the threshold and the saturating counter without overflow.
    // ------------------------------------------------------------------
    assign f_plus1 = {3'b000, i_F} + 11'd1;
    assign th      = (f_plus1 << 2) + f_plus1 + 11'd9;

    always_comb begin
        if (i_sync_n) begin
            lowcnt_d = '0;
        end else if (lowcnt_q == LOWCNT_MAX) begin
            lowcnt_d = lowcnt_q;
        end else begin
            lowcnt_d = lowcnt_q + 11'd1;
        end
    end

    // low_hit looks at the count including the current low cycle, so the
    // resync is taken on the very cycle the low period reaches th.
    assign low_hit       = !i_sync_n && (lowcnt_d >= th);
    // A low period that ends before reaching th is an error report.
    assign short_low_end = i_sync_n && (lowcnt_q != 11'd0) && (lowcnt_q < th);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!i_link_en) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_CGS;
                end
                ST_CGS: begin
                    if (i_sync_n) begin
                        state_d = ST_WAIT_LMFC;
                    end
                end
                ST_WAIT_LMFC: begin
                    // SYNC~ re-asserted before ILA: back to CGS silently.
                    if (!i_sync_n) begin
                        state_d = ST_CGS;
                    end else if (boundary && !realign) begin
                        state_d = ST_ILA;
                    end
                end
                ST_ILA: begin
                    // Resync has priority over a coincident ILA end.
                    if (low_hit || realign) begin
                        state_d = ST_CGS;
                    end else if (i_seq_end) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (low_hit || realign) begin
                        state_d = ST_CGS;
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Lane select is decoded straight from the state
    // register; pulses and the captured phase are computed here and
    // registered below.
    // ------------------------------------------------------------------
    always_comb begin
        sel_c       = SEL_K28;
        nfda_d      = nfda_q;
        seq_start_d = 1'b0;
        sync_err_d  = 1'b0;
        resync_d    = 1'b0;
        ila_abort_d = 1'b0;

        case (state_q)
            ST_ILA:  sel_c = SEL_ILA;
            ST_DATA: sel_c = SEL_DAT;
            default: sel_c = SEL_K28;
        endcase

        if (i_link_en) begin
            case (state_q)
                ST_CGS: begin
                    if (i_sync_n) begin
                        nfda_d = frame_q;
                    end
                end
                ST_WAIT_LMFC: begin
                    // Registered, so the pulse lines up with the LMFC edge
                    // that starts the ILA.
                    if (i_sync_n && boundary && !realign) begin
                        seq_start_d = 1'b1;
                    end
                end
                ST_ILA: begin
                    if (low_hit || realign) begin
                        resync_d    = 1'b1;
                        ila_abort_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (low_hit || realign) begin
                        resync_d = 1'b1;
                    end else if (short_low_end) begin
                        sync_err_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_sel = sel_c;

    // ------------------------------------------------------------------
    // Registers: counters, capture, pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            octet_q     <= '0;
            frame_q     <= '0;
            lowcnt_q    <= '0;
            nfda_q      <= '0;
            seq_start_q <= 1'b0;
            sync_err_q  <= 1'b0;
            resync_q    <= 1'b0;
            ila_abort_q <= 1'b0;
        end else begin
            octet_q     <= octet_d;
            frame_q     <= frame_d;
            lowcnt_q    <= lowcnt_d;
            nfda_q      <= nfda_d;
            seq_start_q <= seq_start_d;
            sync_err_q  <= sync_err_d;
            resync_q    <= resync_d;
            ila_abort_q <= ila_abort_d;
        end
    end

    assign o_octet_pos             = octet_q;
    assign o_frame_pos             = frame_q;
    assign o_no_frame_de_assertion = nfda_q;
    assign o_seq_start             = seq_start_q;
    assign o_sync_err              = sync_err_q;
    assign o_resync                = resync_q;
    assign o_ila_abort             = ila_abort_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// ============================================================================
// tb_tx_link_ctrl -- directed bench for tx_link_ctrl with i_F=1, i_K=3
// (F=2, K=4, 8-cycle multiframe, SYNC~ threshold 19 cycles).
// ============================================================================
module tb_tx_link_ctrl;

    logic       clk;
    logic       rst_n;
    logic       link_en;
    logic       sync_n;
    logic [7:0] cfg_f;
    logic [4:0] cfg_k;
    logic       seq_end;
`ifdef TX_LMFC_SYSREF_EN
    logic       sysref;
`endif
    logic       seq_start;
    logic [4:0] nfda;
    logic [1:0] sel;
    logic [7:0] octet_pos;
    logic [4:0] frame_pos;
    logic       lmfc_edge;
    logic       sync_err;
    logic       resync;
    logic       ila_abort;

    int total;
    int bad;
    int cyc;

    tx_link_ctrl dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_link_en               (link_en),
        .i_sync_n                (sync_n),
        .i_F                     (cfg_f),
        .i_K                     (cfg_k),
        .i_seq_end               (seq_end),
`ifdef TX_LMFC_SYSREF_EN
        .i_sysref                (sysref),
`endif
        .o_seq_start             (seq_start),
        .o_no_frame_de_assertion (nfda),
        .o_sel                   (sel),
        .o_octet_pos             (octet_pos),
        .o_frame_pos             (frame_pos),
        .o_lmfc_edge             (lmfc_edge),
        .o_sync_err              (sync_err),
        .o_resync                (resync),
        .o_ila_abort             (ila_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Frame position of the free-running LMFC at a given cycle since reset.
    function automatic int frame_at(input int c);
        return (c / 2) % 4;
    endfunction

    // Advance one clock, sample 1ns after the edge, check the LMFC counters.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("octet_pos", 32'(octet_pos), 32'(cyc % 2));
        chk("frame_pos", 32'(frame_pos), 32'(frame_at(cyc)));
        chk("lmfc_edge", 32'(lmfc_edge), 32'(cyc % 8 == 0));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_sel"},       32'(sel),       32'd0);
        chk({tag, "_seq_start"}, 32'(seq_start), 32'd0);
        chk({tag, "_nfda"},      32'(nfda),      32'd0);
        chk({tag, "_octet"},     32'(octet_pos), 32'd0);
        chk({tag, "_frame"},     32'(frame_pos), 32'd0);
        chk({tag, "_sync_err"},  32'(sync_err),  32'd0);
        chk({tag, "_resync"},    32'(resync),    32'd0);
        chk({tag, "_ila_abort"}, 32'(ila_abort), 32'd0);
    endtask

    // In CGS: raise SYNC~ now, expect the capture, then the start pulse on
    // the first LMFC edge after the boundary cycle. Returns at that edge.
    task automatic raise_and_ila(input int exp_nfda);
        int c;
        int b;
        int s;
        sync_n = 1'b1;
        c = cyc;
        b = c + 1;
        while (b % 8 != 7) b++;
        s = b + 1;
        tick();
        chk("nfda", 32'(nfda), 32'(exp_nfda));
        while (cyc < s) begin
            chk("wait_seq_start", 32'(seq_start), 32'd0);
            chk("wait_sel", 32'(sel), 32'd0);
            tick();
        end
        chk("ila_seq_start", 32'(seq_start), 32'd1);
        chk("ila_sel", 32'(sel), 32'd1);
    endtask

    // In ILA at iteration 0: hold SYNC~ low; resync + abort on iteration 19.
    task automatic ila_abort_run(input bit coincide);
        for (int i = 0; i < 22; i++) begin
            chk("abort_sel", 32'(sel), (i < 19) ? 32'd1 : 32'd0);
            chk("abort_resync", 32'(resync), 32'(i == 19));
            chk("abort_ila_abort", 32'(ila_abort), 32'(i == 19));
            sync_n  = 1'b0;
            seq_end = coincide && (i == 18);
            tick();
        end
        seq_end = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        link_en = 1'b0;
        sync_n  = 1'b0;
        cfg_f   = 8'd1;
        cfg_k   = 5'd3;
        seq_end = 1'b0;
`ifdef TX_LMFC_SYSREF_EN
        sysref  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        cyc   = 0;

        // Free run while disabled: two full multiframes.
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("disabled_sel", 32'(sel), 32'd0);
        end

        // Link-up: SYNC~ released during frame 2 (cycle 20).
        link_en = 1'b1;
        tick();
        chk("cgs_sel", 32'(sel), 32'd0);
        while (cyc < 20) tick();
        raise_and_ila(2);
        tick();
        chk("ila_pulse_once", 32'(seq_start), 32'd0);
        chk("ila_sel_hold", 32'(sel), 32'd1);
        seq_end = 1'b1;
        tick();
        seq_end = 1'b0;
        chk("data_sel", 32'(sel), 32'd2);

        // Short SYNC~ low (10 cycles) in DATA: one error pulse.
        for (int i = 0; i < 14; i++) begin
            chk("short_sync_err", 32'(sync_err), 32'(i == 11));
            chk("short_sel", 32'(sel), 32'd2);
            chk("short_resync", 32'(resync), 32'd0);
            sync_n = (i < 10) ? 1'b0 : 1'b1;
            tick();
        end

        // Long SYNC~ low in DATA: resync when the 19th low cycle is counted.
        for (int i = 0; i < 22; i++) begin
            chk("resync_pulse", 32'(resync), 32'(i == 19));
            chk("resync_sel", 32'(sel), (i < 19) ? 32'd2 : 32'd0);
            chk("resync_no_err", 32'(sync_err), 32'd0);
            sync_n = 1'b0;
            tick();
        end
        raise_and_ila(frame_at(cyc));

        // Abort in ILA, then again with i_seq_end on the threshold cycle.
        ila_abort_run(1'b0);
        raise_and_ila(frame_at(cyc));
        ila_abort_run(1'b1);
        raise_and_ila(frame_at(cyc));

        // Into DATA, then drop the link enable.
        tick();
        seq_end = 1'b1;
        tick();
        seq_end = 1'b0;
        chk("data2_sel", 32'(sel), 32'd2);
        link_en = 1'b0;
        tick();
        chk("disable_sel", 32'(sel), 32'd0);
        chk("disable_resync", 32'(resync), 32'd0);
        link_en = 1'b1;
        tick();
        chk("reenable_sel", 32'(sel), 32'd0);
        raise_and_ila(frame_at(cyc));

        // Asynchronous reset in the middle of ILA.
        tick();
        chk("pre_reset_sel", 32'(sel), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        link_en = 1'b0;
        sync_n  = 1'b0;
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        repeat (4) tick();
        chk("post_reset_sel", 32'(sel), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
